// File: rtl/balu_rs.sv
// balu_rs: branch reservation station in front of the branch ALU.
// Holds dispatched branch compares until both operands are valid and issues
// one ready entry per cycle. An entry stays allocated until the ALU returns
// its id on res_rs. Entry k has id k+1; id 0 means "none".
// Optional feature macro: BALU_RS_WAKEUP_ISSUE_EN lets an entry whose last
// pending operand arrives on the CDB issue in that same cycle.
// dbg_state exposes each entry's state (2 bits per entry, entry 0 in [1:0]).
module balu_rs #(
  parameter int WIDTH   = 32,
  parameter int RSBIT   = 3,
  parameter int ENTRIES = 4,
  parameter int TAGW    = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic                 disp_valid,
  output logic                 disp_ready,
  input  logic [2:0]           disp_op,
  input  logic [WIDTH-1:0]     disp_vl,
  input  logic [WIDTH-1:0]     disp_vr,
  input  logic                 disp_vl_rdy,
  input  logic                 disp_vr_rdy,
  input  logic [TAGW-1:0]      disp_tl,
  input  logic [TAGW-1:0]      disp_tr,
  output logic [RSBIT-1:0]     disp_rs,
  input  logic                 cdb_valid,
  input  logic [TAGW-1:0]      cdb_tag,
  input  logic [WIDTH-1:0]     cdb_value,
  output logic [RSBIT-1:0]     iss_rs,
  output logic [WIDTH-1:0]     iss_vl,
  output logic [WIDTH-1:0]     iss_vr,
  output logic [2:0]           iss_op,
  input  logic [RSBIT-1:0]     res_rs,
  output logic [2*ENTRIES-1:0] dbg_state
);
  // Dispatch handshake: a dispatch is accepted in a cycle exactly when
  // disp_valid and disp_ready are both high at the rising edge; disp_ready
  // depends only on registered state, and disp_rs is meaningful only then.

  localparam logic [1:0] S_FREE   = 2'd0;
  localparam logic [1:0] S_WAIT   = 2'd1;
  localparam logic [1:0] S_READY  = 2'd2;
  localparam logic [1:0] S_ISSUED = 2'd3;

  logic [1:0]       state_q  [ENTRIES];
  logic [1:0]       state_d  [ENTRIES];
  logic [WIDTH-1:0] vl_q     [ENTRIES];
  logic [WIDTH-1:0] vl_d     [ENTRIES];
  logic [WIDTH-1:0] vr_q     [ENTRIES];
  logic [WIDTH-1:0] vr_d     [ENTRIES];
  logic             vl_rdy_q [ENTRIES];
  logic             vl_rdy_d [ENTRIES];
  logic             vr_rdy_q [ENTRIES];
  logic             vr_rdy_d [ENTRIES];
  logic [TAGW-1:0]  tl_q     [ENTRIES];
  logic [TAGW-1:0]  tl_d     [ENTRIES];
  logic [TAGW-1:0]  tr_q     [ENTRIES];
  logic [TAGW-1:0]  tr_d     [ENTRIES];
  logic [2:0]       op_q     [ENTRIES];
  logic [2:0]       op_d     [ENTRIES];

  // Per-entry view after this cycle's CDB capture.
  logic [WIDTH-1:0]   vl_w [ENTRIES];
  logic [WIDTH-1:0]   vr_w [ENTRIES];
  logic [ENTRIES-1:0] wake_l, wake_r, rdy_l_w, rdy_r_w, woken, cand, free_hit;

  logic             free_found, sel_found, disp_fire;
  logic [RSBIT-1:0] free_idx, sel_idx;
  logic [WIDTH-1:0] sel_vl, sel_vr;
  logic [2:0]       sel_op;

  logic             byp_l_rdy, byp_r_rdy;
  logic [WIDTH-1:0] byp_vl, byp_vr;

  logic [RSBIT-1:0] iss_rs_q;
  logic [WIDTH-1:0] iss_vl_q, iss_vr_q;
  logic [2:0]       iss_op_q;

  // Operands dispatched not-ready can still be caught from the CDB this cycle.
  assign byp_l_rdy = disp_vl_rdy | (cdb_valid & (disp_tl == cdb_tag));
  assign byp_r_rdy = disp_vr_rdy | (cdb_valid & (disp_tr == cdb_tag));
  assign byp_vl    = disp_vl_rdy ? disp_vl : cdb_value;
  assign byp_vr    = disp_vr_rdy ? disp_vr : cdb_value;

  // CDB wakeup, issue candidates and res_rs matching per entry.
  always_comb begin
    for (int k = 0; k < ENTRIES; k++) begin
      wake_l[k]   = cdb_valid && (state_q[k] == S_WAIT) && !vl_rdy_q[k] && (tl_q[k] == cdb_tag);
      wake_r[k]   = cdb_valid && (state_q[k] == S_WAIT) && !vr_rdy_q[k] && (tr_q[k] == cdb_tag);
      vl_w[k]     = wake_l[k] ? cdb_value : vl_q[k];
      vr_w[k]     = wake_r[k] ? cdb_value : vr_q[k];
      rdy_l_w[k]  = vl_rdy_q[k] | wake_l[k];
      rdy_r_w[k]  = vr_rdy_q[k] | wake_r[k];
      woken[k]    = (state_q[k] == S_WAIT) && rdy_l_w[k] && rdy_r_w[k];
`ifdef BALU_RS_WAKEUP_ISSUE_EN
      cand[k]     = (state_q[k] == S_READY) || woken[k];
`else
      cand[k]     = (state_q[k] == S_READY);
`endif
      free_hit[k] = (res_rs == RSBIT'(k + 1)) && (state_q[k] == S_ISSUED);
    end
  end

  // Lowest-index FREE entry for dispatch and lowest-index candidate for issue;
  // scanning downward lets the lowest index win.
  always_comb begin
    free_found = 1'b0;
    free_idx   = '0;
    sel_found  = 1'b0;
    sel_idx    = '0;
    sel_vl     = '0;
    sel_vr     = '0;
    sel_op     = '0;
    for (int k = ENTRIES - 1; k >= 0; k--) begin
      if (state_q[k] == S_FREE) begin
        free_found = 1'b1;
        free_idx   = RSBIT'(k);
      end
      if (cand[k]) begin
        sel_found = 1'b1;
        sel_idx   = RSBIT'(k);
        sel_vl    = vl_w[k];
        sel_vr    = vr_w[k];
        sel_op    = op_q[k];
      end
    end
  end

  assign disp_ready = free_found;
  assign disp_fire  = disp_valid & free_found;
  assign disp_rs    = free_found ? free_idx + RSBIT'(1) : '0;

  // Next entry state: wakeup, issue, free and allocation touch disjoint entries.
  always_comb begin
    for (int k = 0; k < ENTRIES; k++) begin
      state_d[k]  = state_q[k];
      vl_d[k]     = vl_w[k];
      vr_d[k]     = vr_w[k];
      vl_rdy_d[k] = rdy_l_w[k];
      vr_rdy_d[k] = rdy_r_w[k];
      tl_d[k]     = tl_q[k];
      tr_d[k]     = tr_q[k];
      op_d[k]     = op_q[k];
      if (woken[k]) state_d[k] = S_READY;
      if (sel_found && (sel_idx == RSBIT'(k))) state_d[k] = S_ISSUED;
      if (free_hit[k]) state_d[k] = S_FREE;
      if (disp_fire && (free_idx == RSBIT'(k))) begin
        state_d[k]  = (byp_l_rdy && byp_r_rdy) ? S_READY : S_WAIT;
        vl_d[k]     = byp_vl;
        vr_d[k]     = byp_vr;
        vl_rdy_d[k] = byp_l_rdy;
        vr_rdy_d[k] = byp_r_rdy;
        tl_d[k]     = disp_tl;
        tr_d[k]     = disp_tr;
        op_d[k]     = disp_op;
      end
    end
  end

  // Entry state registers; flush discards everything.
  always_ff @(posedge clk) begin
    for (int k = 0; k < ENTRIES; k++) begin
      if (rst || flush) state_q[k] <= S_FREE;
      else              state_q[k] <= state_d[k];
    end
  end

  // Entry payload registers; contents of FREE entries are don't-care.
  always_ff @(posedge clk) begin
    for (int k = 0; k < ENTRIES; k++) begin
      if (rst) begin
        vl_q[k]     <= '0;
        vr_q[k]     <= '0;
        vl_rdy_q[k] <= 1'b0;
        vr_rdy_q[k] <= 1'b0;
        tl_q[k]     <= '0;
        tr_q[k]     <= '0;
        op_q[k]     <= '0;
      end else begin
        vl_q[k]     <= vl_d[k];
        vr_q[k]     <= vr_d[k];
        vl_rdy_q[k] <= vl_rdy_d[k];
        vr_rdy_q[k] <= vr_rdy_d[k];
        tl_q[k]     <= tl_d[k];
        tr_q[k]     <= tr_d[k];
        op_q[k]     <= op_d[k];
      end
    end
  end

  // Issue registers; operands and op hold when nothing is selected.
  always_ff @(posedge clk) begin
    if (rst) begin
      iss_rs_q <= '0;
      iss_vl_q <= '0;
      iss_vr_q <= '0;
      iss_op_q <= '0;
    end else if (flush) begin
      iss_rs_q <= '0;
    end else begin
      iss_rs_q <= sel_found ? sel_idx + RSBIT'(1) : '0;
      if (sel_found) begin
        iss_vl_q <= sel_vl;
        iss_vr_q <= sel_vr;
        iss_op_q <= sel_op;
      end
    end
  end

  assign iss_rs = iss_rs_q;
  assign iss_vl = iss_vl_q;
  assign iss_vr = iss_vr_q;
  assign iss_op = iss_op_q;

  // Debug view of every entry's state.
  always_comb begin
    dbg_state = '0;
    for (int k = 0; k < ENTRIES; k++) dbg_state[2*k +: 2] = state_q[k];
  end
endmodule

// File: tb/tb_balu_rs.sv
// tb_balu_rs: directed scenarios plus randomized traffic for balu_rs,
// checked against a transaction-level model of the station's rules.
module tb_balu_rs;
  localparam int W   = 32;
  localparam int RB  = 3;
  localparam int ENT = 4;
  localparam int TW  = 5;
  localparam int PW  = RB + 3 + 2 * W;

  logic            clk = 1'b0;
  logic            rst, flush, disp_valid, disp_ready;
  logic [2:0]      disp_op;
  logic [W-1:0]    disp_vl, disp_vr;
  logic            disp_vl_rdy, disp_vr_rdy;
  logic [TW-1:0]   disp_tl, disp_tr;
  logic [RB-1:0]   disp_rs;
  logic            cdb_valid;
  logic [TW-1:0]   cdb_tag;
  logic [W-1:0]    cdb_value;
  logic [RB-1:0]   iss_rs;
  logic [W-1:0]    iss_vl, iss_vr;
  logic [2:0]      iss_op;
  logic [RB-1:0]   res_rs;
  logic [2*ENT-1:0] dbg_state;

  // clock / reset block
  always #5 clk = ~clk;

  balu_rs #(.WIDTH(W), .RSBIT(RB), .ENTRIES(ENT), .TAGW(TW)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .disp_valid(disp_valid), .disp_ready(disp_ready), .disp_op(disp_op),
    .disp_vl(disp_vl), .disp_vr(disp_vr),
    .disp_vl_rdy(disp_vl_rdy), .disp_vr_rdy(disp_vr_rdy),
    .disp_tl(disp_tl), .disp_tr(disp_tr), .disp_rs(disp_rs),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_value(cdb_value),
    .iss_rs(iss_rs), .iss_vl(iss_vl), .iss_vr(iss_vr), .iss_op(iss_op),
    .res_rs(res_rs), .dbg_state(dbg_state)
  );

  int n_vec = 0;
  int n_err = 0;
  logic [PW-1:0] exp_q[$];
  int alu_q[$];

  // reference model: 0 FREE, 1 WAIT, 2 READY, 3 ISSUED
  int            m_st [ENT];
  bit            m_hl [ENT];
  bit            m_hr [ENT];
  logic [W-1:0]  m_vl [ENT];
  logic [W-1:0]  m_vr [ENT];
  logic [TW-1:0] m_tl [ENT];
  logic [TW-1:0] m_tr [ENT];
  logic [2:0]    m_op [ENT];
  logic [RB-1:0] e_rs;
  logic [W-1:0]  e_vl, e_vr;
  logic [2:0]    e_op;
  logic          s_rdy;
  logic [RB-1:0] s_rs;

  task automatic check(input string tag, input logic [PW-1:0] got, input logic [PW-1:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int first_free();
    for (int k = 0; k < ENT; k++) if (m_st[k] == 0) return k;
    return -1;
  endfunction

  // One cycle of the station's rules applied to the model.
  task automatic model_step();
    int  ost [ENT];
    bit  wl [ENT];
    bit  wr [ENT];
    int  sel, fi, r;
    bit  cand;
    if (rst) begin
      for (int k = 0; k < ENT; k++) m_st[k] = 0;
      e_rs = '0; e_vl = '0; e_vr = '0; e_op = '0;
      return;
    end
    if (flush) begin
      for (int k = 0; k < ENT; k++) m_st[k] = 0;
      e_rs = '0;
      return;
    end
    fi = first_free();
    for (int k = 0; k < ENT; k++) begin
      ost[k] = m_st[k];
      wl[k]  = (ost[k] == 1) && !m_hl[k] && cdb_valid && (m_tl[k] == cdb_tag);
      wr[k]  = (ost[k] == 1) && !m_hr[k] && cdb_valid && (m_tr[k] == cdb_tag);
    end
    sel = -1;
    for (int k = 0; k < ENT; k++) begin
      cand = (ost[k] == 2);
`ifdef BALU_RS_WAKEUP_ISSUE_EN
      if (ost[k] == 1 && (m_hl[k] || wl[k]) && (m_hr[k] || wr[k])) cand = 1'b1;
`endif
      if (sel < 0 && cand) sel = k;
    end
    for (int k = 0; k < ENT; k++) begin
      if (wl[k]) begin m_vl[k] = cdb_value; m_hl[k] = 1'b1; end
      if (wr[k]) begin m_vr[k] = cdb_value; m_hr[k] = 1'b1; end
      if (ost[k] == 1 && m_hl[k] && m_hr[k]) m_st[k] = 2;
    end
    if (sel >= 0) begin
      e_rs = RB'(sel + 1);
      e_vl = m_vl[sel];
      e_vr = m_vr[sel];
      e_op = m_op[sel];
      m_st[sel] = 3;
      exp_q.push_back({e_rs, e_op, e_vl, e_vr});
    end else begin
      e_rs = '0;
    end
    r = int'(res_rs);
    if (r >= 1 && r <= ENT && ost[r-1] == 3) m_st[r-1] = 0;
    if (disp_valid && fi >= 0) begin
      m_hl[fi] = disp_vl_rdy || (cdb_valid && disp_tl == cdb_tag);
      m_hr[fi] = disp_vr_rdy || (cdb_valid && disp_tr == cdb_tag);
      m_vl[fi] = disp_vl_rdy ? disp_vl : cdb_value;
      m_vr[fi] = disp_vr_rdy ? disp_vr : cdb_value;
      m_tl[fi] = disp_tl;
      m_tr[fi] = disp_tr;
      m_op[fi] = disp_op;
      m_st[fi] = (m_hl[fi] && m_hr[fi]) ? 2 : 1;
    end
  endtask

  // driver tasks
  task automatic idle();
    flush = 1'b0; disp_valid = 1'b0; disp_op = '0;
    disp_vl = '0; disp_vr = '0; disp_vl_rdy = 1'b0; disp_vr_rdy = 1'b0;
    disp_tl = '0; disp_tr = '0;
    cdb_valid = 1'b0; cdb_tag = '0; cdb_value = '0; res_rs = '0;
  endtask

  task automatic disp(input logic [2:0] op, input logic [W-1:0] vl, input logic vlr,
                      input logic [TW-1:0] tl, input logic [W-1:0] vr, input logic vrr,
                      input logic [TW-1:0] tr);
    disp_valid = 1'b1; disp_op = op;
    disp_vl = vl; disp_vl_rdy = vlr; disp_tl = tl;
    disp_vr = vr; disp_vr_rdy = vrr; disp_tr = tr;
  endtask

  task automatic cdb(input logic [TW-1:0] tag, input logic [W-1:0] val);
    cdb_valid = 1'b1; cdb_tag = tag; cdb_value = val;
  endtask

  // Apply the current inputs for one cycle and compare against the model.
  task automatic tick();
    int fi;
    logic [PW-1:0] pkt;
    #1;
    fi = first_free();
    s_rdy = disp_ready;
    s_rs  = disp_rs;
    if (!rst) begin
      check("disp_ready", PW'(disp_ready), PW'(fi >= 0));
      if (disp_valid && fi >= 0) check("disp_rs", PW'(disp_rs), PW'(fi + 1));
    end
    model_step();
    @(posedge clk);
    #1;
    check("iss_rs", PW'(iss_rs), PW'(e_rs));
    check("iss_vl", PW'(iss_vl), PW'(e_vl));
    check("iss_vr", PW'(iss_vr), PW'(e_vr));
    check("iss_op", PW'(iss_op), PW'(e_op));
    for (int k = 0; k < ENT; k++)
      check($sformatf("state%0d", k + 1), PW'(dbg_state[2*k +: 2]), PW'(m_st[k]));
    if (e_rs != '0 && exp_q.size() > 0) begin
      pkt = exp_q.pop_front();
      check("iss_pkt", {iss_rs, iss_op, iss_vl, iss_vr}, pkt);
    end
  endtask

  initial begin
    rst = 1'b1;
    idle();
    tick();
    tick();
    rst = 1'b0;
    check("rst_iss_rs", PW'(iss_rs), PW'(0));
    check("rst_iss_vl", PW'(iss_vl), PW'(0));
    check("rst_state", PW'(dbg_state), PW'(0));

    // fully ready dispatch: issue two cycles later, free after result
    disp(3'd0, 32'h5, 1'b1, 5'd0, 32'h5, 1'b1, 5'd0);
    tick();
    check("t1_ready", PW'(s_rdy), PW'(1));
    check("t1_disp_rs", PW'(s_rs), PW'(1));
    idle(); tick();
    check("t1_iss_rs", PW'(iss_rs), PW'(1));
    check("t1_iss_vl", PW'(iss_vl), PW'(5));
    check("t1_iss_vr", PW'(iss_vr), PW'(5));
    idle(); tick();
    res_rs = 3'd1; tick();
    check("t1_freed", PW'(dbg_state[1:0]), PW'(0));

    // left operand waits on tag 3, CDB delivers 0x10 two cycles later
    idle(); disp(3'd1, 32'h0, 1'b0, 5'd3, 32'h7, 1'b1, 5'd0); tick();
    idle(); tick();
    cdb(5'd3, 32'h10); tick();
`ifdef BALU_RS_WAKEUP_ISSUE_EN
    check("t2_early_rs", PW'(iss_rs), PW'(1));
    check("t2_early_vl", PW'(iss_vl), PW'(32'h10));
`else
    check("t2_not_yet", PW'(iss_rs), PW'(0));
`endif
    idle(); tick();
`ifndef BALU_RS_WAKEUP_ISSUE_EN
    check("t2_iss_rs", PW'(iss_rs), PW'(1));
    check("t2_iss_vl", PW'(iss_vl), PW'(32'h10));
`endif
    res_rs = 3'd1; tick();
    idle(); tick();

    // fill all entries, 5th dispatch ignored
    disp(3'd2, 32'h0, 1'b0, 5'd4, 32'h1, 1'b1, 5'd0); tick();
    check("t3_rs1", PW'(s_rs), PW'(1));
    disp(3'd2, 32'h0, 1'b0, 5'd9, 32'h2, 1'b1, 5'd0); tick();
    check("t3_rs2", PW'(s_rs), PW'(2));
    disp(3'd2, 32'h0, 1'b0, 5'd6, 32'h3, 1'b1, 5'd0); tick();
    check("t3_rs3", PW'(s_rs), PW'(3));
    disp(3'd2, 32'h0, 1'b0, 5'd9, 32'h4, 1'b1, 5'd0); tick();
    check("t3_rs4", PW'(s_rs), PW'(4));
    disp(3'd1, 32'h0, 1'b0, 5'd12, 32'h5, 1'b1, 5'd0); tick();
    check("t3_full", PW'(s_rdy), PW'(0));
    check("t3_all_wait", PW'(dbg_state), PW'(8'b01010101));
    idle(); cdb(5'd6, 32'h66); tick();
`ifdef BALU_RS_WAKEUP_ISSUE_EN
    check("t3_iss3", PW'(iss_rs), PW'(3));
`endif
    idle(); tick();
`ifndef BALU_RS_WAKEUP_ISSUE_EN
    check("t3_iss3", PW'(iss_rs), PW'(3));
`endif
    check("t3_vl", PW'(iss_vl), PW'(32'h66));
    res_rs = 3'd3; tick();

    // wake entries 2 and 4 together: issue 2 then 4
    idle(); cdb(5'd9, 32'h99); tick();
`ifdef BALU_RS_WAKEUP_ISSUE_EN
    check("t4_first", PW'(iss_rs), PW'(2));
`endif
    idle(); tick();
`ifdef BALU_RS_WAKEUP_ISSUE_EN
    check("t4_second", PW'(iss_rs), PW'(4));
`else
    check("t4_first", PW'(iss_rs), PW'(2));
`endif
    idle(); tick();
`ifndef BALU_RS_WAKEUP_ISSUE_EN
    check("t4_second", PW'(iss_rs), PW'(4));
`endif
    res_rs = 3'd2; tick();
    res_rs = 3'd4; tick();
    idle(); cdb(5'd4, 32'h44); tick();
    idle(); tick();
    tick();
    check("t5_e1_issued", PW'(dbg_state[1:0]), PW'(3));

    // flush with entry 1 ISSUED, entry 2 WAIT and a dispatch in the same cycle
    disp(3'd0, 32'h0, 1'b0, 5'd2, 32'h1, 1'b1, 5'd0); tick();
    check("t5_e2_wait", PW'(dbg_state[3:2]), PW'(1));
    idle(); flush = 1'b1; disp(3'd0, 32'h0, 1'b0, 5'd11, 32'h1, 1'b1, 5'd0); tick();
    check("t5_flushed", PW'(dbg_state), PW'(0));
    check("t5_iss_rs", PW'(iss_rs), PW'(0));
    idle(); res_rs = 3'd1; tick();
    check("t5_stale_res", PW'(dbg_state), PW'(0));

    // dispatch bypass: tag matches the CDB in the dispatch cycle
    idle(); disp(3'd2, 32'h0, 1'b0, 5'd8, 32'h4, 1'b1, 5'd0); cdb(5'd8, 32'h33); tick();
    check("t6_ready", PW'(dbg_state[1:0]), PW'(2));
    idle(); tick();
    check("t6_iss_rs", PW'(iss_rs), PW'(1));
    check("t6_iss_vl", PW'(iss_vl), PW'(32'h33));
    idle(); tick();
    res_rs = 3'd1; tick();
    idle(); tick();

    // randomized traffic; the bench acts as the branch ALU
    for (int c = 0; c < 3000; c++) begin
      idle();
      disp_valid  = ($urandom_range(0, 2) != 0);
      disp_op     = 3'($urandom_range(0, 7));
      disp_vl     = $urandom;
      disp_vr     = $urandom;
      disp_vl_rdy = 1'($urandom_range(0, 1));
      disp_vr_rdy = 1'($urandom_range(0, 1));
      disp_tl     = TW'($urandom_range(0, 3));
      disp_tr     = TW'($urandom_range(0, 3));
      cdb_valid   = 1'($urandom_range(0, 1));
      cdb_tag     = TW'($urandom_range(0, 3));
      cdb_value   = $urandom;
      if (alu_q.size() > 0 && $urandom_range(0, 2) != 0) res_rs = RB'(alu_q.pop_front());
      else if ($urandom_range(0, 15) == 0) res_rs = RB'($urandom_range(0, 7));
      flush = ($urandom_range(0, 63) == 0);
      tick();
      if (flush) alu_q.delete();
      if (e_rs != '0) alu_q.push_back(int'(e_rs));
    end

    check("exp_q_drained", PW'(exp_q.size()), PW'(0));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
